// File: rtl/ctlr_multi_port_if.sv
// Bus and pad signals shared between the CPU side and the multi-port
// controller interface.
interface ctlr_multi_port_if #(
    parameter int NUM_PORTS = 2
);
    logic                 clock_en;
    logic [15:0]          addr;
    logic                 r_en;
    logic [7:0]           w_data;
    logic [NUM_PORTS-1:0] ctlr_data;
    logic                 ctlr_latch;
    logic [NUM_PORTS-1:0] ctlr_pulse;
    logic [7:0]           button_data_rd;
    logic                 rd_valid;
    logic [NUM_PORTS-1:0] overrun;

    modport master (
        output clock_en, addr, r_en, w_data, ctlr_data,
        input  ctlr_latch, ctlr_pulse, button_data_rd, rd_valid, overrun
    );

    modport slave (
        input  clock_en, addr, r_en, w_data, ctlr_data,
        output ctlr_latch, ctlr_pulse, button_data_rd, rd_valid, overrun
    );
endinterface

// File: rtl/ctlr_multi_port_interface.sv
// Multi-port NES-style controller reader: shared latch, one shift-clock
// sequencer per port, live strobe reads, saturation and overrun detection.
//
// state       | meaning
// ST_IDLE     | port ready to accept a read
// ST_PULSE_HI | ctlr_pulse high, counting PULSE_LEN clock_en cycles
// ST_PULSE_LO | ctlr_pulse low recovery, counting PULSE_LEN clock_en cycles
module ctlr_multi_port_interface #(
    parameter int          NUM_PORTS     = 2,
    parameter logic [15:0] BASE_ADDR     = 16'h4016,
    parameter int          BITS_PER_PORT = 8,
    parameter int          PULSE_LEN     = 3,
    parameter logic [6:0]  OPEN_BUS_HI   = 7'h20
) (
    input logic              clock,
    input logic              reset,
    ctlr_multi_port_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PULSE_HI = 2'd1,
        ST_PULSE_LO = 2'd2
    } port_state_t;

    localparam int CNT_W  = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam int RCNT_W = $clog2(BITS_PER_PORT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PULSE_LEN - 1);
    localparam logic [RCNT_W-1:0] RCNT_FULL = RCNT_W'(BITS_PER_PORT);

    logic                 strobe_q;
    logic [NUM_PORTS-1:0] overrun_q;
    logic [NUM_PORTS-1:0] last_bit_q;
    logic [RCNT_W-1:0]    read_cnt_q [NUM_PORTS];
    port_state_t          state_q    [NUM_PORTS];
    port_state_t          state_d    [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_q      [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_d      [NUM_PORTS];
    logic [NUM_PORTS-1:0] rd_hit;
    logic [NUM_PORTS-1:0] accept;
    logic [NUM_PORTS-1:0] busy_hit;
    logic [NUM_PORTS-1:0] sel_bit;
    logic                 wr_strobe;
    logic [7:0]           rd_data_q;
    logic                 rd_valid_q;
    logic                 unused_w_data;

    assign unused_w_data = ^bus.w_data[7:1];

    // Decode CPU accesses; only port 0's address takes strobe writes.
    always_comb begin
        wr_strobe = bus.clock_en && !bus.r_en && (bus.addr == BASE_ADDR);
        rd_hit    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_hit[p] = bus.clock_en && bus.r_en && (bus.addr == BASE_ADDR + 16'(p));
        end
    end

    // Classify each read and pick the bit it returns. A busy port reports
    // its previous bit rather than sampling a pad mid-shift.
    always_comb begin
        accept   = '0;
        busy_hit = '0;
        sel_bit  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            busy_hit[p] = rd_hit[p] && !strobe_q && (state_q[p] != ST_IDLE);
            accept[p]   = rd_hit[p] && !strobe_q && (state_q[p] == ST_IDLE)
                          && (read_cnt_q[p] < RCNT_FULL);
            if (strobe_q)
                sel_bit[p] = ~bus.ctlr_data[p];
            else if (state_q[p] != ST_IDLE)
                sel_bit[p] = last_bit_q[p];
            else if (read_cnt_q[p] < RCNT_FULL)
                sel_bit[p] = ~bus.ctlr_data[p];
            else
                sel_bit[p] = 1'b1;
        end
    end

    // Per-port pulse sequencer next-state; a strobe write aborts every port.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            state_d[p] = state_q[p];
            cnt_d[p]   = cnt_q[p];
            if (wr_strobe) begin
                state_d[p] = ST_IDLE;
                cnt_d[p]   = '0;
            end else if (bus.clock_en) begin
                case (state_q[p])
                    ST_IDLE: begin
                        if (accept[p]) begin
                            state_d[p] = ST_PULSE_HI;
                            cnt_d[p]   = '0;
                        end
                    end
                    ST_PULSE_HI: begin
                        if (cnt_q[p] == CNT_LAST) begin
                            state_d[p] = ST_PULSE_LO;
                            cnt_d[p]   = '0;
                        end else begin
                            cnt_d[p] = cnt_q[p] + CNT_W'(1);
                        end
                    end
                    ST_PULSE_LO: begin
                        if (cnt_q[p] == CNT_LAST) begin
                            state_d[p] = ST_IDLE;
                            cnt_d[p]   = '0;
                        end else begin
                            cnt_d[p] = cnt_q[p] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[p] = ST_IDLE;
                        cnt_d[p]   = '0;
                    end
                endcase
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clock) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (reset) begin
                state_q[p] <= ST_IDLE;
                cnt_q[p]   <= '0;
            end else begin
                state_q[p] <= state_d[p];
                cnt_q[p]   <= cnt_d[p];
            end
        end
    end

    // Strobe, per-port report position, last captured bit and overrun flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            strobe_q   <= 1'b0;
            overrun_q  <= '0;
            last_bit_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) read_cnt_q[p] <= '0;
        end else if (wr_strobe) begin
            strobe_q  <= bus.w_data[0];
            overrun_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++) read_cnt_q[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (accept[p]) begin
                    read_cnt_q[p] <= read_cnt_q[p] + RCNT_W'(1);
                    last_bit_q[p] <= ~bus.ctlr_data[p];
                end
                if (busy_hit[p]) overrun_q[p] <= 1'b1;
            end
        end
    end

    // Registered read data; unmapped or write cycles drop rd_valid and hold data.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else if (bus.clock_en) begin
            rd_valid_q <= |rd_hit;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (rd_hit[p]) rd_data_q <= {OPEN_BUS_HI, sel_bit[p]};
            end
        end
    end

    // Drive pad and CPU-side outputs.
    always_comb begin
        bus.ctlr_latch     = strobe_q;
        bus.button_data_rd = rd_data_q;
        bus.rd_valid       = rd_valid_q;
        bus.overrun        = overrun_q;
        bus.ctlr_pulse     = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            bus.ctlr_pulse[p] = (state_q[p] == ST_PULSE_HI);
        end
    end
endmodule

// File: tb/tb_ctlr_multi_port_interface.sv
// Bench for ctlr_multi_port_interface: directed steps followed by random
// traffic, each cycle compared against a tick-based reference model.
module tb_ctlr_multi_port_interface;
    localparam int          NP   = 2;
    localparam int          PL   = 3;
    localparam int          NB   = 8;
    localparam logic [15:0] BASE = 16'h4016;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    ctlr_multi_port_if #(.NUM_PORTS(NP)) bus ();

    ctlr_multi_port_interface #(
        .NUM_PORTS(NP), .BASE_ADDR(BASE), .BITS_PER_PORT(NB),
        .PULSE_LEN(PL), .OPEN_BUS_HI(7'h20)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: time measured in clock_en ticks. A port that accepts a
    // read at tick T pulses while tick < T+PL and is busy while tick < T+2*PL.
    int         tick = 0;
    bit         m_strobe;
    int         m_cnt      [NP];
    int         m_busy_end [NP];
    int         m_pend     [NP];
    bit         m_last     [NP];
    bit         m_ovr      [NP];
    bit         m_valid;
    logic [7:0] m_data;

    logic [7:0] exp_seq [8] = '{8'h41, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41, 8'h40, 8'h41};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int pre;
        bit hit;
        bit b;
        if (reset) begin
            m_strobe = 1'b0;
            m_valid  = 1'b0;
            m_data   = 8'h00;
            for (int p = 0; p < NP; p++) begin
                m_cnt[p] = 0; m_busy_end[p] = tick; m_pend[p] = tick;
                m_ovr[p] = 1'b0; m_last[p] = 1'b0;
            end
        end else if (bus.clock_en) begin
            pre  = tick;
            tick = tick + 1;
            if (!bus.r_en && bus.addr == BASE) begin
                m_strobe = bus.w_data[0];
                m_valid  = 1'b0;
                for (int p = 0; p < NP; p++) begin
                    m_cnt[p] = 0; m_busy_end[p] = tick; m_pend[p] = tick; m_ovr[p] = 1'b0;
                end
            end else begin
                hit = 1'b0;
                for (int p = 0; p < NP; p++) begin
                    if (bus.r_en && bus.addr == BASE + 16'(p)) begin
                        hit = 1'b1;
                        if (m_strobe) begin
                            b = ~bus.ctlr_data[p];
                        end else if (pre < m_busy_end[p]) begin
                            b = m_last[p];
                            m_ovr[p] = 1'b1;
                        end else if (m_cnt[p] < NB) begin
                            b = ~bus.ctlr_data[p];
                            m_cnt[p]++;
                            m_last[p]     = b;
                            m_pend[p]     = tick + PL;
                            m_busy_end[p] = tick + 2 * PL;
                        end else begin
                            b = 1'b1;
                        end
                        m_data = {7'h20, b};
                    end
                end
                m_valid = hit;
            end
        end
    endtask

    task automatic check_all();
        logic [NP-1:0] ep;
        logic [NP-1:0] eo;
        for (int p = 0; p < NP; p++) begin
            ep[p] = (tick < m_pend[p]);
            eo[p] = m_ovr[p];
        end
        chk("latch",    bus.ctlr_latch,     m_strobe);
        chk("pulse",    bus.ctlr_pulse,     ep);
        chk("overrun",  bus.overrun,        eo);
        chk("rd_valid", bus.rd_valid,       m_valid);
        chk("rd_data",  bus.button_data_rd, m_data);
    endtask

    task automatic cyc(input bit ce, input logic [15:0] a, input bit rd, input logic [7:0] wd);
        bus.clock_en = ce;
        bus.addr     = a;
        bus.r_en     = rd;
        bus.w_data   = wd;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 16'h0000, 1'b1, 8'h00);
    endtask

    initial begin
        int         npulse;
        bit         d1;
        logic [7:0] rep;
        int         sel;
        bit         ce;
        bit         rd;
        logic [15:0] a;

        bus.ctlr_data = '1;
        bus.clock_en  = 1'b0;
        bus.addr      = 16'h0000;
        bus.r_en      = 1'b1;
        bus.w_data    = 8'h00;

        // Reset, including one edge with clock_en low.
        reset = 1'b1;
        cyc(1'b0, 16'h0000, 1'b1, 8'h00);
        cyc(1'b1, BASE, 1'b1, 8'h00);
        chk("rst_valid", bus.rd_valid, 0);
        chk("rst_data",  bus.button_data_rd, 8'h00);
        chk("rst_pulse", bus.ctlr_pulse, 0);
        chk("rst_ovr",   bus.overrun, 0);
        chk("rst_latch", bus.ctlr_latch, 0);
        reset = 1'b0;

        // Latch pulse by strobe writes.
        cyc(1'b1, BASE, 1'b0, 8'h01);
        chk("latch_hi", bus.ctlr_latch, 1);
        idle(2);
        cyc(1'b1, BASE, 1'b0, 8'h00);
        chk("latch_lo", bus.ctlr_latch, 0);
        idle(2);

        // Full report on port 0, then two saturated reads.
        rep = 8'b10110001;
        for (int k = 0; k < 10; k++) begin
            bus.ctlr_data[0] = (k < 8) ? ~rep[k] : 1'($urandom);
            bus.ctlr_data[1] = 1'($urandom);
            cyc(1'b1, BASE, 1'b1, 8'h00);
            chk("rep_valid", bus.rd_valid, 1);
            chk("rep_data",  bus.button_data_rd, (k < 8) ? exp_seq[k] : 8'h41);
            npulse = int'(bus.ctlr_pulse[0]);
            for (int j = 0; j < 7; j++) begin
                bus.ctlr_data[0] = 1'($urandom);
                cyc(1'b1, 16'h0000, 1'b1, 8'h00);
                npulse += int'(bus.ctlr_pulse[0]);
            end
            chk("rep_pulse_cnt", npulse, (k < 8) ? 3 : 0);
        end

        // Live strobe-mode reads on port 1.
        cyc(1'b1, BASE, 1'b0, 8'h01);
        for (int k = 0; k < 6; k++) begin
            d1 = 1'(k & 1);
            bus.ctlr_data[1] = d1;
            cyc(1'b1, BASE + 16'd1, 1'b1, 8'h00);
            chk("strobe_live",    bus.button_data_rd, {7'h20, ~d1});
            chk("strobe_nopulse", bus.ctlr_pulse[1], 0);
        end

        // Overrun: second read two cycles after the first.
        cyc(1'b1, BASE, 1'b0, 8'h00);
        idle(1);
        bus.ctlr_data[0] = 1'b0;
        cyc(1'b1, BASE, 1'b1, 8'h00);
        chk("ovr_first", bus.button_data_rd, 8'h41);
        npulse = int'(bus.ctlr_pulse[0]);
        bus.ctlr_data[0] = 1'b1;
        idle(1);
        npulse += int'(bus.ctlr_pulse[0]);
        cyc(1'b1, BASE, 1'b1, 8'h00);
        npulse += int'(bus.ctlr_pulse[0]);
        chk("ovr_second", bus.button_data_rd, 8'h41);
        chk("ovr_flag",   bus.overrun[0], 1);
        for (int j = 0; j < 8; j++) begin
            idle(1);
            npulse += int'(bus.ctlr_pulse[0]);
        end
        chk("ovr_one_pulse", npulse, 3);
        cyc(1'b1, BASE, 1'b0, 8'h00);
        chk("ovr_clear", bus.overrun, 0);

        // Strobe write aborts a running pulse on port 1.
        cyc(1'b1, BASE + 16'd1, 1'b1, 8'h00);
        idle(1);
        chk("abort_pre", bus.ctlr_pulse[1], 1);
        cyc(1'b1, BASE, 1'b0, 8'h00);
        chk("abort_strobe", bus.ctlr_pulse[1], 0);
        cyc(1'b1, BASE + 16'd1, 1'b1, 8'h00);
        chk("abort_restart", bus.ctlr_pulse[1], 1);
        idle(7);

        // Reset mid-sequence.
        cyc(1'b1, BASE, 1'b1, 8'h00);
        idle(1);
        reset = 1'b1;
        cyc(1'b1, 16'h0000, 1'b1, 8'h00);
        chk("rst_mid_pulse", bus.ctlr_pulse, 0);
        chk("rst_mid_valid", bus.rd_valid, 0);
        chk("rst_mid_data",  bus.button_data_rd, 8'h00);
        reset = 1'b0;
        idle(2);

        // Random traffic with clock_en gaps and rare resets.
        for (int i = 0; i < 600; i++) begin
            ce  = ($urandom_range(0, 99) < 85);
            sel = $urandom_range(0, 9);
            a   = (sel < 4) ? BASE : (sel < 8) ? BASE + 16'd1 : (sel == 8) ? BASE + 16'd2 : 16'h1234;
            rd  = ($urandom_range(0, 15) != 0);
            bus.ctlr_data = NP'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            cyc(ce, a, rd, 8'($urandom));
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
